// File: rtl/dp_issue_unit.sv
// dp_issue_unit
//   Issue/collect wrapper around an external fixed-latency datapath.
//   Operand triples are registered onto dp_a/dp_b/dp_c and tracked by a tag
//   pipeline v[0..LATENCY]. Results arrive on dp_x/dp_z and are captured into
//   a DEPTH-entry result FIFO. in_ready admits a new triple only while
//   (ops in flight + FIFO entries) < DEPTH, so a capture always finds space.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid, in_ready        upstream handshake for the operand triple
//   in_a, in_b, in_c          operand triple (W_IN, signed)
//   dp_a, dp_b, dp_c          registered operands to the datapath
//   dp_x, dp_z                registered datapath results (W_OUT, signed)
//   out_valid, out_ready      downstream handshake for the FIFO head
//   out_x, out_z              FIFO head results, zero while out_valid=0
//   busy                      any op in flight or any FIFO entry held
module dp_issue_unit #(
    parameter int W_IN    = 64,
    parameter int W_OUT   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_a,
    input  logic [W_IN-1:0]  in_b,
    input  logic [W_IN-1:0]  in_c,
    output logic [W_IN-1:0]  dp_a,
    output logic [W_IN-1:0]  dp_b,
    output logic [W_IN-1:0]  dp_c,
    input  logic [W_OUT-1:0] dp_x,
    input  logic [W_OUT-1:0] dp_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_x,
    output logic [W_OUT-1:0] out_z,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for inflight + fifo_count, whose maximum is LATENCY+1+DEPTH.
    localparam int CW = $clog2(LATENCY + DEPTH + 2);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [LATENCY:0]  v;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [W_OUT-1:0]  mem_x [DEPTH];
    logic [W_OUT-1:0]  mem_z [DEPTH];
    logic              issue;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        inflight = '0;
        for (int j = 0; j <= LATENCY; j++) begin
            inflight = inflight + CW'(v[j]);
        end
    end

    // Gated by rst so in_ready reads 0 while reset is held; built from
    // registered counts only, so a pop this cycle frees its slot next cycle.
    assign in_ready  = rst && ((inflight + fifo_count) < CW'(DEPTH));
    assign issue     = in_valid && in_ready;
    assign push      = v[LATENCY];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_x     = out_valid ? mem_x[rd_ptr] : '0;
    assign out_z     = out_valid ? mem_z[rd_ptr] : '0;
    assign busy      = (inflight != '0) || out_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v          <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_c       <= '0;
        end else begin
            // Tag pipeline never stalls: a tag reaching v[LATENCY] marks the
            // cycle in which its result sits on dp_x/dp_z.
            v <= {v[LATENCY-1:0], issue};
            if (issue) begin
                dp_a <= in_a;
                dp_b <= in_b;
                dp_c <= in_c;
            end
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; out_valid masks stale contents and the
    // tag pipeline (which is reset) is the only thing that enables a write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= dp_x;
            mem_z[wr_ptr] <= dp_z;
        end
    end

endmodule

// File: tb/tb_dp_issue_unit.sv
// Testbench for dp_issue_unit: directed scenarios on a DEPTH=4 instance plus a
// DEPTH=8 instance for streaming (with LATENCY=2, three tags in flight plus a
// held head already reach DEPTH=4, which throttles issue to every other cycle).
module tb_dp_issue_unit;

    localparam int W_IN  = 64;
    localparam int W_OUT = 32;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {x, z} = {(a+b)[31:0], (a-c)[31:0]}
    function automatic logic [63:0] exp_xz(input logic [W_IN-1:0] a, b, c);
        logic [W_IN-1:0] s;
        logic [W_IN-1:0] d;
        s = a + b;
        d = a - c;
        return {s[W_OUT-1:0], d[W_OUT-1:0]};
    endfunction

    // ---------------- DUT 1 (DEPTH=4) ----------------
    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [W_IN-1:0]   in_a, in_b, in_c, dp_a, dp_b, dp_c;
    logic [W_OUT-1:0]  dp_x, dp_z, out_x, out_z;

    dp_issue_unit #(.W_IN(W_IN), .W_OUT(W_OUT), .LATENCY(LAT), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_x(dp_x), .dp_z(dp_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_z(out_z), .busy(busy)
    );

    // ---------------- DUT 2 (DEPTH=8) ----------------
    logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [W_IN-1:0]   s_in_a, s_in_b, s_in_c, s_dp_a, s_dp_b, s_dp_c;
    logic [W_OUT-1:0]  s_dp_x, s_dp_z, s_out_x, s_out_z;

    dp_issue_unit #(.W_IN(W_IN), .W_OUT(W_OUT), .LATENCY(LAT), .DEPTH(8)) u_dut_deep (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_c(s_in_c),
        .dp_a(s_dp_a), .dp_b(s_dp_b), .dp_c(s_dp_c),
        .dp_x(s_dp_x), .dp_z(s_dp_z),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_x(s_out_x), .out_z(s_out_z), .busy(s_busy)
    );

    // ---------------- datapath models: LAT-stage register chains ----------------
    logic [W_OUT-1:0] px [LAT];
    logic [W_OUT-1:0] pz [LAT];
    logic [W_OUT-1:0] qx [LAT];
    logic [W_OUT-1:0] qz [LAT];
    logic [63:0]      p_in, q_in;

    assign p_in = exp_xz(dp_a, dp_b, dp_c);
    assign q_in = exp_xz(s_dp_a, s_dp_b, s_dp_c);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                px[i] <= '0; pz[i] <= '0; qx[i] <= '0; qz[i] <= '0;
            end
        end else begin
            px[0] <= p_in[63:32]; pz[0] <= p_in[31:0];
            qx[0] <= q_in[63:32]; qz[0] <= q_in[31:0];
            for (int i = 1; i < LAT; i++) begin
                px[i] <= px[i-1]; pz[i] <= pz[i-1];
                qx[i] <= qx[i-1]; qz[i] <= qz[i-1];
            end
        end
    end

    assign dp_x   = px[LAT-1];
    assign dp_z   = pz[LAT-1];
    assign s_dp_x = qx[LAT-1];
    assign s_dp_z = qz[LAT-1];

    // ---------------- scoreboard for DUT 1, sampled on the falling edge ----------------
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    int          n_issue = 0;
    int          n_pop   = 0;

    always @(negedge clk) begin
        if (rst && in_valid && in_ready) begin
            exp_q.push_back(exp_xz(in_a, in_b, in_c));
            n_issue++;
        end
        if (rst && out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("pop_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_x", 64'(out_x), 64'(mon_e[63:32]));
                check("pop_z", 64'(out_z), 64'(mon_e[31:0]));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W_IN-1:0] a, b, c);
        in_valid = v; in_a = a; in_b = b; in_c = c;
    endtask

    task automatic drive_s(input logic v, input logic [W_IN-1:0] a, b, c);
        s_in_valid = v; s_in_a = a; s_in_b = b; s_in_c = c;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_x"},     64'(out_x),     64'd0);
        check({tag, "_out_z"},     64'(out_z),     64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_dp_a"},      dp_a,           64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] ea, eb;
    int          k;

    initial begin
        drive(1'b0, '0, '0, '0);
        drive_s(1'b0, '0, '0, '0);
        out_ready   = 1'b0;
        s_out_ready = 1'b0;

        // ---- reset state ----
        #12;
        check_all_zero("rst");
        check("rst_s_in_ready", 64'(s_in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        step();
        check("post_rst_in_ready_e1", 64'(in_ready), 64'd1);

        // ---- single op: a=5 b=3 c=1 ----
        out_ready = 1'b1;
        drive(1'b1, 64'd5, 64'd3, 64'd1);
        step();                                   // edge 0: issue
        drive(1'b0, '0, '0, '0);
        check("s1_dp_a", dp_a, 64'd5);
        check("s1_busy_e0", 64'(busy), 64'd1);
        step(); step();                           // edges 1, 2
        check("s1_valid_e2", 64'(out_valid), 64'd0);
        step();                                   // edge 3: captured
        check("s1_valid_e3", 64'(out_valid), 64'd1);
        check("s1_x", 64'(out_x), 64'd8);
        check("s1_z", 64'(out_z), 64'd4);
        step();                                   // edge 4: popped
        check("s1_busy_e4", 64'(busy), 64'd0);
        check("s1_valid_e4", 64'(out_valid), 64'd0);

        // ---- signed pass-through: a=-1 b=0 c=1 ----
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1);
        step();
        drive(1'b0, '0, '0, '0);
        step(); step(); step();
        check("s2_valid", 64'(out_valid), 64'd1);
        check("s2_x", 64'(out_x), 64'h0000_0000_FFFF_FFFF);
        check("s2_z", 64'(out_z), 64'h0000_0000_FFFF_FFFE);
        wait_idle("s2_idle");

        // ---- backpressure ----
        out_ready = 1'b0;
        n_issue = 0;
        n_pop   = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(100 + i), 64'(i), 64'(2 * i));
            step();
        end
        check("s3_issues", 64'(n_issue), 64'd4);
        check("s3_in_ready_full", 64'(in_ready), 64'd0);
        check("s3_out_valid", 64'(out_valid), 64'd1);
        check("s3_head_x", 64'(out_x), 64'd100);
        drive(1'b1, 64'd200, 64'd1, 64'd2);
        out_ready = 1'b1;
        #1;
        check("s3_no_same_cycle_ready", 64'(in_ready), 64'd0);
        step();                                   // first pop
        check("s3_ready_after_pop", 64'(in_ready), 64'd1);
        check("s3_issues_at_pop", 64'(n_issue), 64'd4);
        step();                                   // next issue
        check("s3_issue_after_pop", 64'(n_issue), 64'd5);
        drive(1'b0, '0, '0, '0);
        wait_idle("s3_idle");
        check("s3_pops", 64'(n_pop), 64'd5);

        // ---- streaming 20 triples on the DEPTH=8 instance ----
        s_out_ready = 1'b1;
        k = 0;
        for (int t = 0; t < 30; t++) begin
            if (t < 20) begin
                drive_s(1'b1, 64'(1000 + 7 * t), 64'(t), 64'(3 * t));
                #1;
                check("s4_in_ready", 64'(s_in_ready), 64'd1);
            end else begin
                drive_s(1'b0, '0, '0, '0);
            end
            step();
            if (s_out_valid) begin
                if (k < 20) begin
                    ea = exp_xz(64'(1000 + 7 * k), 64'(k), 64'(3 * k));
                    check("s4_x", 64'(s_out_x), 64'(ea[63:32]));
                    check("s4_z", 64'(s_out_z), 64'(ea[31:0]));
                end
                k++;
            end else if (k > 0 && k < 20) begin
                check("s4_gap", 64'(s_out_valid), 64'd1);
            end
        end
        check("s4_results", 64'(k), 64'd20);
        check("s4_idle", 64'(s_busy), 64'd0);

        // ---- simultaneous push/pop at fifo_count=1, 10 ops ----
        for (int p = 0; p < 5; p++) begin
            out_ready = 1'b0;
            ea = exp_xz(64'(10 + 2 * p), 64'(p), 64'd1);
            eb = exp_xz(64'(11 + 2 * p), 64'd2, 64'(p));
            drive(1'b1, 64'(10 + 2 * p), 64'(p), 64'd1);
            step();                               // A issued
            drive(1'b1, 64'(11 + 2 * p), 64'd2, 64'(p));
            step();                               // B issued
            drive(1'b0, '0, '0, '0);
            step(); step();                       // A captured, B at tag end
            check("s5_head_a", 64'(out_x), 64'(ea[63:32]));
            out_ready = 1'b1;
            step();                               // pop A, push B
            check("s5_pp_valid", 64'(out_valid), 64'd1);
            check("s5_pp_head_x", 64'(out_x), 64'(eb[63:32]));
            check("s5_pp_head_z", 64'(out_z), 64'(eb[31:0]));
            step();                               // pop B
            check("s5_empty", 64'(out_valid), 64'd0);
        end
        wait_idle("s5_idle");

        // ---- reset mid-flight ----
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(50 + i), 64'd1, 64'd1);
            step();
        end
        drive(1'b0, '0, '0, '0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("s6_in_rst");
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("s6_no_stale_valid", 64'(out_valid), 64'd0);
            check("s6_no_stale_busy", 64'(busy), 64'd0);
        end
        drive(1'b1, 64'd7, 64'd8, 64'd9);
        step();                                   // issue
        drive(1'b0, '0, '0, '0);
        step(); step();
        check("s6_new_valid_early", 64'(out_valid), 64'd0);
        step();
        check("s6_new_valid", 64'(out_valid), 64'd1);
        check("s6_new_x", 64'(out_x), 64'd15);
        check("s6_new_z", 64'(out_z), 64'h0000_0000_FFFF_FFFE);
        wait_idle("s6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
